// File: rtl/axi_ram_pkg.sv
// Shared types and the address-decode helper for the AXI4-Lite RAM responder.
// Imported by the memory array and by the top level.
package axi_ram_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_RESP = 2'b10
    } rd_state_t;

    localparam int RD_CNT_W = 8;

    // Below-base addresses wrap to huge offsets, so one unsigned compare covers both ends.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] depth);
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] == 2'b00) && ((off >> 2) < depth);
    endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4-Lite bus bundle shared by the pipeline master and the data-memory responder.
// Handshake: a beat transfers on a rising edge where VALID and READY are both high.
interface axi4_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport SLAVE (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport MASTER (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_ram_array.sv
// Word-addressed 32-bit RAM with a byte-enabled write port and a registered read port.
// A same-edge read and write of one word returns the pre-write contents.
module axi_ram_array #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [3:0]       i_wstrb,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    input  logic             i_rclr,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Clear wins so reset and error responses present zero data.
    always_ff @(posedge clk) begin
        if (i_rclr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite data-memory responder with independent write and read channel FSMs.
// Optional macro AXI_RAM_WAIT_EN inserts READ_WAIT extra cycles of read latency.
module axi_lite_ram_slave
    import axi_ram_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          READ_WAIT   = 2
) (
    input  logic      clk,
    input  logic      rst,
    axi4_if.SLAVE     inf,
    output wr_state_t o_wr_state,
    output rd_state_t o_rd_state
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int STRB_W = DATA_W / 8;

    // Write channel state
    wr_state_t           r_wr_state, w_wr_state_nxt;
    logic                r_aw_got, w_aw_got_nxt;
    logic                r_w_got, w_w_got_nxt;
    logic [ADDR_W-1:0]   r_awaddr, w_awaddr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [STRB_W-1:0]   r_wstrb, w_wstrb_nxt;
    logic                r_awready, w_awready_nxt;
    logic                r_wready, w_wready_nxt;
    logic                r_bvalid, w_bvalid_nxt;
    resp_t               r_bresp, w_bresp_nxt;

    logic                w_aw_hs, w_w_hs, w_aw_have, w_w_have;
    logic [ADDR_W-1:0]   w_cur_awaddr;
    logic [DATA_W-1:0]   w_cur_wdata;
    logic [STRB_W-1:0]   w_cur_wstrb;
    logic                w_wr_ok;
    logic [IDX_W-1:0]    w_wr_idx;
    logic                w_mem_we;

    // Read channel state
    rd_state_t           r_rd_state, w_rd_state_nxt;
    logic                r_arready, w_arready_nxt;
    logic                r_rvalid, w_rvalid_nxt;
    resp_t               r_rresp, w_rresp_nxt;
`ifdef AXI_RAM_WAIT_EN
    logic [RD_CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
`endif

    logic                w_ar_hs;
    logic                w_rd_ok;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [31:0]         w_rdata;

    // A beat captured on this edge counts as held, so AW+W together commit immediately.
    assign w_aw_hs      = inf.AWVALID && r_awready;
    assign w_w_hs       = inf.WVALID && r_wready;
    assign w_aw_have    = r_aw_got || w_aw_hs;
    assign w_w_have     = r_w_got || w_w_hs;
    assign w_cur_awaddr = r_aw_got ? r_awaddr : inf.AWADDR;
    assign w_cur_wdata  = r_w_got ? r_wdata : inf.WDATA;
    assign w_cur_wstrb  = r_w_got ? r_wstrb : inf.WSTRB;
    assign w_wr_ok      = addr_ok(32'(w_cur_awaddr), BASE_ADDR, 32'(DEPTH_WORDS));
    assign w_wr_idx     = IDX_W'((32'(w_cur_awaddr) - BASE_ADDR) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_aw_got   <= w_aw_got_nxt;
            r_w_got    <= w_w_got_nxt;
            r_awaddr   <= w_awaddr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wstrb    <= w_wstrb_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_got_nxt   = r_aw_got;
        w_w_got_nxt    = r_w_got;
        w_awaddr_nxt   = r_awaddr;
        w_wdata_nxt    = r_wdata;
        w_wstrb_nxt    = r_wstrb;
        w_awready_nxt  = r_awready;
        w_wready_nxt   = r_wready;
        w_bvalid_nxt   = r_bvalid;
        w_bresp_nxt    = r_bresp;
        w_mem_we       = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_awaddr_nxt = inf.AWADDR;
                end
                if (w_w_hs) begin
                    w_wdata_nxt = inf.WDATA;
                    w_wstrb_nxt = inf.WSTRB;
                end
                w_aw_got_nxt = w_aw_have;
                w_w_got_nxt  = w_w_have;
                if (w_aw_have && w_w_have) begin
                    w_mem_we       = w_wr_ok;
                    w_bresp_nxt    = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                    w_bvalid_nxt   = 1'b1;
                    w_awready_nxt  = 1'b0;
                    w_wready_nxt   = 1'b0;
                    w_wr_state_nxt = W_RESP;
                end else begin
                    w_awready_nxt = !w_aw_have;
                    w_wready_nxt  = !w_w_have;
                end
            end
            W_RESP: begin
                if (inf.BREADY) begin
                    w_bvalid_nxt   = 1'b0;
                    w_aw_got_nxt   = 1'b0;
                    w_w_got_nxt    = 1'b0;
                    w_awready_nxt  = 1'b1;
                    w_wready_nxt   = 1'b1;
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: begin
                w_wr_state_nxt = W_IDLE;
            end
        endcase
    end

    assign w_ar_hs  = inf.ARVALID && r_arready;
    assign w_rd_ok  = addr_ok(32'(inf.ARADDR), BASE_ADDR, 32'(DEPTH_WORDS));
    assign w_rd_idx = IDX_W'((32'(inf.ARADDR) - BASE_ADDR) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
`ifdef AXI_RAM_WAIT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rresp    <= w_rresp_nxt;
`ifdef AXI_RAM_WAIT_EN
            r_wait_cnt <= w_wait_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_arready_nxt  = r_arready;
        w_rvalid_nxt   = r_rvalid;
        w_rresp_nxt    = r_rresp;
`ifdef AXI_RAM_WAIT_EN
        w_wait_cnt_nxt = r_wait_cnt;
`endif
        case (r_rd_state)
            R_IDLE: begin
                w_arready_nxt = 1'b1;
                if (w_ar_hs) begin
                    w_arready_nxt = 1'b0;
                    w_rresp_nxt   = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
`ifdef AXI_RAM_WAIT_EN
                    if (READ_WAIT == 0) begin
                        w_rvalid_nxt   = 1'b1;
                        w_rd_state_nxt = R_RESP;
                    end else begin
                        w_wait_cnt_nxt = RD_CNT_W'(READ_WAIT - 1);
                        w_rd_state_nxt = R_WAIT;
                    end
`else
                    w_rvalid_nxt   = 1'b1;
                    w_rd_state_nxt = R_RESP;
`endif
                end
            end
`ifdef AXI_RAM_WAIT_EN
            // Read data was already latched at the AR handshake; only the response waits.
            R_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_rvalid_nxt   = 1'b1;
                    w_rd_state_nxt = R_RESP;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 1'b1;
                end
            end
`endif
            R_RESP: begin
                if (inf.RREADY) begin
                    w_rvalid_nxt   = 1'b0;
                    w_arready_nxt  = 1'b1;
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: begin
                w_rd_state_nxt = R_IDLE;
            end
        endcase
    end

    axi_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we && !rst),
        .i_waddr (w_wr_idx),
        .i_wstrb (4'(w_cur_wstrb)),
        .i_wdata (32'(w_cur_wdata)),
        .i_re    (w_ar_hs && w_rd_ok && !rst),
        .i_rclr  (rst || (w_ar_hs && !w_rd_ok)),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rdata)
    );

    assign inf.AWREADY = r_awready;
    assign inf.WREADY  = r_wready;
    assign inf.BVALID  = r_bvalid;
    assign inf.BRESP   = r_bresp;
    assign inf.ARREADY = r_arready;
    assign inf.RVALID  = r_rvalid;
    assign inf.RRESP   = r_rresp;
    assign inf.RDATA   = DATA_W'(w_rdata);

    assign o_wr_state = r_wr_state;
    assign o_rd_state = r_rd_state;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed bench for axi_lite_ram_slave: handshake timing, byte strobes, SLVERR,
// backpressure, same-edge read/write ordering and reset behaviour.
module tb_axi_lite_ram_slave;
    import axi_ram_pkg::*;

`ifdef AXI_RAM_WAIT_EN
    localparam int EXP_RLAT = 3;
`else
    localparam int EXP_RLAT = 1;
`endif

    logic      clk;
    logic      rst;
    wr_state_t wr_state;
    rd_state_t rd_state;
    int        checks;
    int        errors;

    axi4_if bus ();

    axi_lite_ram_slave dut (
        .clk        (clk),
        .rst        (rst),
        .inf        (bus),
        .o_wr_state (wr_state),
        .o_rd_state (rd_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_fire, w_fire, b_fire, done;
        done = 1'b0;
        resp = 2'b11;
        bus.AWADDR = a; bus.AWVALID = 1'b1;
        bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
        bus.BREADY = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            aw_fire = bus.AWVALID && bus.AWREADY;
            w_fire  = bus.WVALID && bus.WREADY;
            b_fire  = bus.BVALID && bus.BREADY;
            if (b_fire) resp = bus.BRESP;
            @(negedge clk);
            if (aw_fire) bus.AWVALID = 1'b0;
            if (w_fire) bus.WVALID = 1'b0;
            if (b_fire) done = 1'b1;
        end
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        check("wr_done", 32'(done), 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic ar_fire, r_fire, done;
        done = 1'b0;
        d = 32'hxxxx_xxxx;
        resp = 2'b11;
        bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            ar_fire = bus.ARVALID && bus.ARREADY;
            r_fire  = bus.RVALID && bus.RREADY;
            if (r_fire) begin
                d = bus.RDATA;
                resp = bus.RRESP;
            end
            @(negedge clk);
            if (ar_fire) bus.ARVALID = 1'b0;
            if (r_fire) done = 1'b1;
        end
        bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        check("rd_done", 32'(done), 32'd1);
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        while (!bus.RVALID && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rvalid_seen", 32'(bus.RVALID), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [1:0]  br;
        int          lat;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(bus.AWREADY), 32'd0);
        check("rst_wready", 32'(bus.WREADY), 32'd0);
        check("rst_arready", 32'(bus.ARREADY), 32'd0);
        check("rst_bvalid", 32'(bus.BVALID), 32'd0);
        check("rst_rvalid", 32'(bus.RVALID), 32'd0);
        check("rst_bresp", 32'(bus.BRESP), 32'd0);
        check("rst_rresp", 32'(bus.RRESP), 32'd0);
        check("rst_rdata", bus.RDATA, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", 32'(bus.AWREADY), 32'd1);
        check("post_rst_wready", 32'(bus.WREADY), 32'd1);
        check("post_rst_arready", 32'(bus.ARREADY), 32'd1);

        // AW and W in the same cycle: BVALID one cycle later
        bus.AWADDR = 32'h10; bus.AWVALID = 1'b1;
        bus.WDATA = 32'hDEAD_BEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        check("t1_bvalid", 32'(bus.BVALID), 32'd1);
        check("t1_bresp", 32'(bus.BRESP), 32'd0);
        check("t1_awready_low", 32'(bus.AWREADY), 32'd0);
        check("t1_wstate", 32'(wr_state), 32'(W_RESP));
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
        @(negedge clk);
        check("t1_bvalid_clr", 32'(bus.BVALID), 32'd0);
        check("t1_awready_back", 32'(bus.AWREADY), 32'd1);
        bus.BREADY = 1'b0;

        // Read it back and measure latency
        bus.ARADDR = 32'h10; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        check("t1_arready_low", 32'(bus.ARREADY), 32'd0);
        wait_rvalid(lat);
        check("t1_rd_latency", 32'(lat + 1), 32'(EXP_RLAT));
        check("t1_rdata", bus.RDATA, 32'hDEAD_BEEF);
        check("t1_rresp", 32'(bus.RRESP), 32'd0);
        bus.RREADY = 1'b1;
        @(negedge clk);
        check("t1_rvalid_clr", 32'(bus.RVALID), 32'd0);
        check("t1_arready_back", 32'(bus.ARREADY), 32'd1);
        bus.RREADY = 1'b0;

        // W three cycles ahead of AW
        bus.WDATA = 32'h1122_3344; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        check("t2_wready_low", 32'(bus.WREADY), 32'd0);
        check("t2_awready_high", 32'(bus.AWREADY), 32'd1);
        bus.WVALID = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_no_bvalid", 32'(bus.BVALID), 32'd0);
        bus.AWADDR = 32'h20; bus.AWVALID = 1'b1;
        @(negedge clk);
        check("t2_bvalid", 32'(bus.BVALID), 32'd1);
        bus.AWVALID = 1'b0; bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        axi_write(32'h20, 32'hAABB_CCDD, 4'b0100, br);
        check("t2_strb_bresp", 32'(br), 32'd0);
        axi_read(32'h20, rd, rr);
        check("t2_strb_rdata", rd, 32'h11BB_3344);

        // Error responses and untouched memory
        axi_write(32'h0, 32'hCAFE_0000, 4'hF, br);
        check("t3_w0_bresp", 32'(br), 32'd0);
        axi_read(32'h4002, rd, rr);
        check("t3_misalign_rresp", 32'(rr), 32'd2);
        check("t3_misalign_rdata", rd, 32'd0);
        axi_write(32'h1000, 32'h5555_5555, 4'hF, br);
        check("t3_oor_bresp", 32'(br), 32'd2);
        axi_read(32'h0, rd, rr);
        check("t3_w0_intact", rd, 32'hCAFE_0000);
        axi_write(32'h12, 32'h1234_5678, 4'hF, br);
        check("t3_wmis_bresp", 32'(br), 32'd2);
        axi_write(32'h10, 32'hFFFF_FFFF, 4'h0, br);
        check("t3_nostrb_bresp", 32'(br), 32'd0);
        axi_read(32'h10, rd, rr);
        check("t3_w10_intact", rd, 32'hDEAD_BEEF);
        axi_write(32'hFFC, 32'h0F0F_0F0F, 4'hF, br);
        check("t3_last_bresp", 32'(br), 32'd0);
        axi_read(32'hFFC, rd, rr);
        check("t3_last_rdata", rd, 32'h0F0F_0F0F);
        check("t3_last_rresp", 32'(rr), 32'd0);

        // B backpressure with a second write waiting
        bus.AWADDR = 32'h40; bus.AWVALID = 1'b1;
        bus.WDATA = 32'hA5A5_0040; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        bus.BREADY = 1'b0;
        @(negedge clk);
        check("t4_bvalid", 32'(bus.BVALID), 32'd1);
        bus.AWADDR = 32'h44; bus.WDATA = 32'h5A5A_0044;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_bvalid_hold", 32'(bus.BVALID), 32'd1);
            check("t4_bresp_hold", 32'(bus.BRESP), 32'd0);
            check("t4_awready_low", 32'(bus.AWREADY), 32'd0);
            check("t4_wready_low", 32'(bus.WREADY), 32'd0);
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        check("t4_bvalid_clr", 32'(bus.BVALID), 32'd0);
        check("t4_awready_back", 32'(bus.AWREADY), 32'd1);
        bus.BREADY = 1'b0;
        @(negedge clk);
        check("t4_second_bvalid", 32'(bus.BVALID), 32'd1);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;

        // R backpressure with a second read waiting
        bus.ARADDR = 32'h40; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
        @(negedge clk);
        bus.ARADDR = 32'h44;
        wait_rvalid(lat);
        check("t4_r40_data", bus.RDATA, 32'hA5A5_0040);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_rvalid_hold", 32'(bus.RVALID), 32'd1);
            check("t4_rdata_hold", bus.RDATA, 32'hA5A5_0040);
            check("t4_arready_low", 32'(bus.ARREADY), 32'd0);
        end
        bus.RREADY = 1'b1;
        @(negedge clk);
        check("t4_rvalid_clr", 32'(bus.RVALID), 32'd0);
        check("t4_arready_back", 32'(bus.ARREADY), 32'd1);
        bus.RREADY = 1'b0;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        wait_rvalid(lat);
        check("t4_r44_data", bus.RDATA, 32'h5A5A_0044);
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;

        // Same-edge AR and write commit to one word
        axi_write(32'h30, 32'h1, 4'hF, br);
        bus.AWADDR = 32'h30; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h2; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h30; bus.ARVALID = 1'b1;
        @(negedge clk);
        check("t5_bvalid", 32'(bus.BVALID), 32'd1);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0; bus.BREADY = 1'b1;
        wait_rvalid(lat);
        check("t5_old_data", bus.RDATA, 32'h1);
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0; bus.BREADY = 1'b0;
        axi_read(32'h30, rd, rr);
        check("t5_new_data", rd, 32'h2);

        // Reset while a write response is pending
        bus.AWADDR = 32'h50; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h0000_0050; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        check("t6_bvalid", 32'(bus.BVALID), 32'd1);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t6_bvalid_drop", 32'(bus.BVALID), 32'd0);
        check("t6_awready_rst", 32'(bus.AWREADY), 32'd0);
        check("t6_wstate", 32'(wr_state), 32'(W_IDLE));
        check("t6_rstate", 32'(rd_state), 32'(R_IDLE));
        rst = 1'b0;
        @(negedge clk);
        check("t6_awready_back", 32'(bus.AWREADY), 32'd1);
        check("t6_wready_back", 32'(bus.WREADY), 32'd1);
        check("t6_arready_back", 32'(bus.ARREADY), 32'd1);
        axi_read(32'h10, rd, rr);
        check("t6_mem_kept", rd, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
